// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the sequential divider: state encoding,
// default datapath width and the quotient reported on divide-by-zero.
package cpu_pkg;
  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam logic [DIV_W-1:0] DIVZ_QUOT = '1;
endpackage

// File: rtl/div_seq_ctrl_if.sv
// EX-stage <-> divider bundle: request/operands in, stall/status/results out.
interface div_seq_ctrl_if import cpu_pkg::*; #(parameter int WIDTH = DIV_W);
  logic             start;
  logic             op_signed;
  logic             annul;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, op_signed, annul, a, b,
    input  stall, busy, result_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, op_signed, annul, a, b,
    output stall, busy, result_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract the
// divisor and keep the difference when it is non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    // rem < divisor, so the shifted value is below 2^(WIDTH+1) and the top bit of diff is its sign
    diff    = shifted - {1'b0, divisor};
    if (!diff[WIDTH+1]) begin
      rem_next = diff[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: sign-magnitude restoring divide, one bit per
// cycle, holding the pipeline until quotient (LO) and remainder (HI) are ready.
module div_seq_ctrl import cpu_pkg::*; #(
  parameter int WIDTH = DIV_W
) (
  input logic          clk,
  input logic          rst,
  div_seq_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state_reg, state_next;
  logic [WIDTH:0]   rem_reg, rem_next;
  logic [WIDTH-1:0] quo_reg, quo_next;
  logic [WIDTH:0]   dvsr_reg, dvsr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sign_q_reg, sign_q_next;
  logic             sign_r_reg, sign_r_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             dbz_reg, dbz_next;
  logic             stall, result_valid;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

  // |most negative| still fits in WIDTH unsigned bits, so the dividend needs no extra bit
  assign a_mag = (bus.op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (dvsr_reg),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvsr_reg      <= '0;
      cnt_reg       <= '0;
      sign_q_reg    <= 1'b0;
      sign_r_reg    <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rem_reg       <= rem_next;
      quo_reg       <= quo_next;
      dvsr_reg      <= dvsr_next;
      cnt_reg       <= cnt_next;
      sign_q_reg    <= sign_q_next;
      sign_r_reg    <= sign_r_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rem_next       = rem_reg;
    quo_next       = quo_reg;
    dvsr_next      = dvsr_reg;
    cnt_next       = cnt_reg;
    sign_q_next    = sign_q_reg;
    sign_r_next    = sign_r_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;
    stall          = 1'b0;
    result_valid   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.annul) begin
          stall = 1'b1;
          if (bus.b == '0) begin
            state_next     = DONE;
            quotient_next  = WIDTH'(DIVZ_QUOT);
            remainder_next = bus.a;
            dbz_next       = 1'b1;
          end else begin
            state_next  = CALC;
            rem_next    = '0;
            quo_next    = a_mag;
            dvsr_next   = {1'b0, b_mag};
            cnt_next    = '0;
            sign_q_next = bus.op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            sign_r_next = bus.op_signed & bus.a[WIDTH-1];
          end
        end
      end
      CALC: begin
        stall = 1'b1;
        if (bus.annul) begin
          state_next = IDLE;
        end else begin
          rem_next = step_rem;
          quo_next = step_quo;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(WIDTH - 1)) state_next = FIX;
        end
      end
      FIX: begin
        stall = 1'b1;
        if (bus.annul) begin
          state_next = IDLE;
        end else begin
          quotient_next  = sign_q_reg ? -quo_reg : quo_reg;
          remainder_next = sign_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
          dbz_next       = 1'b0;
          state_next     = DONE;
        end
      end
      DONE: begin
        result_valid = !bus.annul;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.stall        = stall;
  assign bus.busy         = (state_reg != IDLE);
  assign bus.result_valid = result_valid;
  assign bus.quotient     = quotient_reg;
  assign bus.remainder    = remainder_reg;
  assign bus.div_by_zero  = dbz_reg;
endmodule
